control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute controller sitting directly upstream of the datapath.
//  Fetches 32-bit instructions over a valid/ready handshake and decodes them.
//  Drives the datapath's one-hot register write select, ALU op select, source read selects and immediate bus.
//  Keeps a program counter and a retired-instruction counter.
// PARAMETERS
//  DATA_W  32  datapath word width (register_set width)
//  NREG    16  register count; register_select width (one-hot)
//  PC_W    16  program counter / retired counter width
// PORTS
//  clock            in   1       single system clock, rising edge
//  clear            in   1       asynchronous, active-low reset (clear=0 resets)
//  run              in   1       level; start fetching from IDLE
//  instr            in   32      instruction word from instruction memory
//  instr_valid      in   1       instr is valid
//  instr_ready      out  1       controller accepts instr this cycle
//  pc               out  PC_W    instruction address
//  register_select  out  NREG    one-hot destination write strobe to datapath
//  register_set     out  DATA_W  sign-extended immediate to datapath
//  imm_write        out  1       datapath writes register_set (not ALU result)
//  op_select        out  4       ALU operation
//  rb_sel, rc_sel   out  4 each  ALU source register indices
//  illegal          out  1       one-cycle pulse: undefined opcode
//  busy             out  1       state is not IDLE or HALTED
//  halted           out  1       HALT executed; sticky until clear
//  retired          out  PC_W    retired-instruction count
// BEHAVIOUR
//  Reset: every output 0, state IDLE, IR 0. Reset mid-instruction aborts with no write.
//  Instruction format:
//   - op[31:27], ra[26:23], rb[22:19], rc[18:15]
//   - imm[18:0] (LDI only; overlaps rc), sign-extended to DATA_W
//  Opcodes:
//   - 0x00-0x0F ALU: op_select = op[3:0]
//   - 0x10 LDI
//   - 0x1E NOP
//   - 0x1F HALT
//   - all others illegal
//  FSM:
//   - IDLE -> FETCH when run=1.
//   - FETCH: instr_ready=1. On instr_valid&instr_ready, latch IR and go to DECODE.
//     Otherwise stay in FETCH (no timeout).
//   - DECODE (1 cycle): HALT -> HALTED; all other opcodes -> EXEC.
//   - EXEC (1 cycle): ALU only, drive op_select/rb_sel/rc_sel. Illegal: illegal=1.
//   - WRITE (1 cycle):
//     - ALU: op_select/rb_sel/rc_sel held stable; register_select = onehot(ra).
//     - LDI: register_select = onehot(ra), register_set = sext(imm), imm_write=1, op_select=0.
//     - NOP/illegal: register_select=0.
//     - Then pc+=1, retired+=1, -> FETCH.
//   - HALTED: halted=1, busy=0, run ignored; exit only via clear.
//  Outputs outside the states listed above are 0.
//  register_select is never multi-hot and is nonzero only in WRITE.
//  Throughput: 4 cycles per instruction when instr_valid is held high.
//  pc and retired wrap modulo 2^PC_W. HALT increments neither counter.
//  run deasserted mid-program: no effect; it is sampled only in IDLE.
//  All registers are r0..r15 general purpose; r0 is not hardwired.
// STRUCTURE
//  Shared include risc_defs.vh:
//   - opcode `defines (OP_LDI, OP_NOP, OP_HALT)
//   - field bit positions
//   - FSM state encodings
//  Sub-module reg_decoder: 4-to-NREG one-hot decoder with enable, instantiated for register_select.
// TESTING
//  1. Reset: pulse clear=0 during EXEC -> all outputs 0, pc=0, retired=0, busy=0. Next run restarts at FETCH.
//  2. LDI r0,5, instr=32'h80000005:
//     - WRITE: register_select=16'h0001, register_set=32'd5, imm_write=1.
//     - Then pc=1, retired=1.
//  3. LDI r1,-1, instr=32'h8087FFFF -> register_select=16'h0002, register_set=32'hFFFFFFFF.
//  4. ALU op 3 r2=r0,r1, instr=32'h19008000:
//     - op_select=4'b0011, rb_sel=0, rc_sel=1 in EXEC and WRITE.
//     - register_select=16'h0004 in WRITE only.
//     - Next handshake exactly 4 cycles after the previous one.
//  5. Hold instr_valid=0 for 3 cycles in FETCH -> instr_ready stays 1, no write, pc unchanged.
//  6. Illegal 0x15 then HALT 0x1F:
//     - illegal high 1 cycle, no write, pc+1.
//     - HALT: halted=1, busy=0, pc/retired unchanged.
//     - run toggling ignored until clear.
//  7. PC_W=2: retire 4 NOPs -> pc sequence 1,2,3,0 and retired wraps to 0.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// rtl/control_sequencer_pkg.sv - shared field positions, opcodes and state types for the control sequencer
//
// Purpose: one place for the instruction-word layout, the opcode values the
// sequencer recognises, the FSM state type and the opcode classifier, so the
// top level and any future decode logic agree on the encoding.
// Ports: none (package).
package control_sequencer_pkg;

  // Instruction word layout: op[31:27] ra[26:23] rb[22:19] rc[18:15].
  // The LDI immediate occupies [18:0] and therefore overlaps rc.
  localparam int INSTR_W = 32;
  localparam int OP_HI   = 31;
  localparam int OP_LO   = 27;
  localparam int RA_HI   = 26;
  localparam int RA_LO   = 23;
  localparam int RB_HI   = 22;
  localparam int RB_LO   = 19;
  localparam int RC_HI   = 18;
  localparam int RC_LO   = 15;
  localparam int IMM_W   = 19;
  localparam int IDX_W   = 4;

  // Opcodes 0x00-0x0F are ALU operations; the low four bits select the op.
  localparam logic [4:0] OP_LDI  = 5'h10;
  localparam logic [4:0] OP_NOP  = 5'h1E;
  localparam logic [4:0] OP_HALT = 5'h1F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WRITE,
    ST_HALTED
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LDI,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  // Map a 5-bit opcode onto the behaviour class the FSM cares about.
  function automatic op_class_t classify(input logic [4:0] op);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    if (op[4] == 1'b0) begin
      cls = CLS_ALU;
    end else if (op == OP_LDI) begin
      cls = CLS_LDI;
    end else if (op == OP_NOP) begin
      cls = CLS_NOP;
    end else if (op == OP_HALT) begin
      cls = CLS_HALT;
    end
    return cls;
  endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// rtl/control_sequencer_reg_decoder.sv - index-to-one-hot register write strobe decoder
//
// Purpose: turns a register index into the one-hot write strobe consumed by the
// datapath. With enable low the output is all zeros, so the strobe can never be
// multi-hot and is inactive whenever the sequencer is not writing.
// Ports:
//   index   in   IDX_W   destination register index
//   enable  in   1       write this cycle
//   onehot  out  NREG    one-hot write strobe (zero when disabled or index out of range)
module reg_decoder #(
  parameter int NREG  = 16,
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0] index,
  input  logic             enable,
  output logic [NREG-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    // Indices beyond NREG are dropped rather than aliased onto a real register.
    if (enable && (int'(index) < NREG)) begin
      onehot[index] = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fetch/decode/execute/write controller driving the datapath selects
//
// Purpose: fetches 32-bit instructions over a valid/ready handshake, decodes
// them and sequences the datapath: ALU op and source selects, one-hot
// destination strobe, sign-extended immediate. Keeps a program counter and a
// retired-instruction counter. Each instruction takes FETCH, DECODE, EXEC and
// WRITE (4 cycles with instr_valid held high); HALT parks in HALTED until clear.
// Ports:
//   clock            in   1       system clock, rising edge
//   clear            in   1       asynchronous active-low reset
//   run              in   1       start fetching (sampled only in IDLE)
//   instr            in   32      instruction word
//   instr_valid      in   1       instr is valid
//   instr_ready      out  1       instruction accepted this cycle (FETCH)
//   pc               out  PC_W    instruction address
//   register_select  out  NREG    one-hot destination write strobe (WRITE only)
//   register_set     out  DATA_W  sign-extended LDI immediate
//   imm_write        out  1       datapath writes register_set rather than ALU result
//   op_select        out  4       ALU operation
//   rb_sel, rc_sel   out  4       ALU source register indices
//   illegal          out  1       one-cycle pulse for an undefined opcode
//   busy             out  1       not IDLE and not HALTED
//   halted           out  1       HALT executed, sticky until clear
//   retired          out  PC_W    retired-instruction count
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int PC_W   = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic [31:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [PC_W-1:0]   pc,
  output logic [NREG-1:0]   register_select,
  output logic [DATA_W-1:0] register_set,
  output logic              imm_write,
  output logic [3:0]        op_select,
  output logic [3:0]        rb_sel,
  output logic [3:0]        rc_sel,
  output logic              illegal,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   retired
);

  state_t             state;
  state_t             state_next;
  logic [INSTR_W-1:0] ir;
  logic               write_en;

  // Fields of the latched instruction.
  logic [4:0]         ir_op;
  logic [IDX_W-1:0]   ir_ra;
  logic [IDX_W-1:0]   ir_rb;
  logic [IDX_W-1:0]   ir_rc;
  logic [DATA_W-1:0]  ir_imm;
  op_class_t          ir_class;

  assign ir_op    = ir[OP_HI:OP_LO];
  assign ir_ra    = ir[RA_HI:RA_LO];
  assign ir_rb    = ir[RB_HI:RB_LO];
  assign ir_rc    = ir[RC_HI:RC_LO];
  assign ir_imm   = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
  assign ir_class = classify(ir_op);

  // State, instruction register and counters. Counters advance only on the
  // WRITE cycle, so a clear that lands mid-instruction never retires it and
  // HALT (which skips WRITE) never counts.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= ST_IDLE;
      ir      <= '0;
      pc      <= '0;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == ST_FETCH && instr_valid) begin
        ir <= instr;
      end
      if (state == ST_WRITE) begin
        pc      <= pc + PC_W'(1);
        retired <= retired + PC_W'(1);
      end
    end
  end

  // Next state and datapath controls. Everything defaults to zero so that any
  // output not explicitly driven in a state is inactive there.
  always_comb begin
    state_next   = state;
    instr_ready  = 1'b0;
    busy         = 1'b0;
    halted       = 1'b0;
    op_select    = '0;
    rb_sel       = '0;
    rc_sel       = '0;
    illegal      = 1'b0;
    imm_write    = 1'b0;
    register_set = '0;
    write_en     = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run) begin
          state_next = ST_FETCH;
        end
      end

      ST_FETCH: begin
        busy        = 1'b1;
        instr_ready = 1'b1;
        if (instr_valid) begin
          state_next = ST_DECODE;
        end
      end

      ST_DECODE: begin
        busy = 1'b1;
        if (ir_class == CLS_HALT) begin
          state_next = ST_HALTED;
        end else begin
          state_next = ST_EXEC;
        end
      end

      ST_EXEC: begin
        busy = 1'b1;
        if (ir_class == CLS_ALU) begin
          op_select = ir_op[3:0];
          rb_sel    = ir_rb;
          rc_sel    = ir_rc;
        end
        if (ir_class == CLS_ILLEGAL) begin
          illegal = 1'b1;
        end
        state_next = ST_WRITE;
      end

      ST_WRITE: begin
        busy = 1'b1;
        // ALU selects stay stable through WRITE so the datapath result is
        // still valid when the destination strobe fires.
        if (ir_class == CLS_ALU) begin
          op_select = ir_op[3:0];
          rb_sel    = ir_rb;
          rc_sel    = ir_rc;
          write_en  = 1'b1;
        end
        if (ir_class == CLS_LDI) begin
          imm_write    = 1'b1;
          register_set = ir_imm;
          write_en     = 1'b1;
        end
        state_next = ST_FETCH;
      end

      ST_HALTED: begin
        halted = 1'b1;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  reg_decoder #(
    .NREG  (NREG),
    .IDX_W (IDX_W)
  ) u_reg_decoder (
    .index  (ir_ra),
    .enable (write_en),
    .onehot (register_select)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clock;
  logic        clear;
  logic        run;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;
  logic [15:0] register_select;
  logic [31:0] register_set;
  logic        imm_write;
  logic [3:0]  op_select;
  logic [3:0]  rb_sel;
  logic [3:0]  rc_sel;
  logic        illegal;
  logic        busy;
  logic        halted;
  logic [15:0] retired;

  logic        run_w;
  logic [31:0] instr_w;
  logic        valid_w;
  logic        ready_w;
  logic [1:0]  pc_w;
  logic [15:0] regsel_w;
  logic [31:0] regset_w;
  logic        immw_w;
  logic [3:0]  op_w;
  logic [3:0]  rb_w;
  logic [3:0]  rc_w;
  logic        illegal_w;
  logic        busy_w;
  logic        halted_w;
  logic [1:0]  retired_w;

  control_sequencer dut (
    .clock           (clock),
    .clear           (clear),
    .run             (run),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .pc              (pc),
    .register_select (register_select),
    .register_set    (register_set),
    .imm_write       (imm_write),
    .op_select       (op_select),
    .rb_sel          (rb_sel),
    .rc_sel          (rc_sel),
    .illegal         (illegal),
    .busy            (busy),
    .halted          (halted),
    .retired         (retired)
  );

  control_sequencer #(.PC_W(2)) dut_w (
    .clock           (clock),
    .clear           (clear),
    .run             (run_w),
    .instr           (instr_w),
    .instr_valid     (valid_w),
    .instr_ready     (ready_w),
    .pc              (pc_w),
    .register_select (regsel_w),
    .register_set    (regset_w),
    .imm_write       (immw_w),
    .op_select       (op_w),
    .rb_sel          (rb_w),
    .rc_sel          (rc_w),
    .illegal         (illegal_w),
    .busy            (busy_w),
    .halted          (halted_w),
    .retired         (retired_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Instruction-level reference state.
  logic [15:0] m_pc;
  logic [15:0] m_ret;
  int          last_hs;
  bit          chain;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ready"},   32'(instr_ready), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_halted"},  32'(halted), 32'd0);
    chk({tag, "_regsel"},  32'(register_select), 32'd0);
    chk({tag, "_regset"},  register_set, 32'd0);
    chk({tag, "_immw"},    32'(imm_write), 32'd0);
    chk({tag, "_ctl"},     32'({op_select, rb_sel, rc_sel, illegal}), 32'd0);
    chk({tag, "_pc"},      32'(pc), 32'd0);
    chk({tag, "_retired"}, 32'(retired), 32'd0);
  endtask

  // Present one instruction (after 'gap' idle FETCH cycles) and check every
  // phase of it against the architectural rules for that opcode.
  task automatic exec_instr(input logic [31:0] w, input int gap);
    logic [31:0] opc, ra, rb, rc, imm, exp_op, exp_rb, exp_rc, exp_sel;
    bit alu, ldi, nop, hlt, ill;
    opc = w >> 27;
    ra  = (w >> 23) & 32'hF;
    rb  = (w >> 19) & 32'hF;
    rc  = (w >> 15) & 32'hF;
    imm = w & 32'h7FFFF;
    if ((imm & 32'h40000) != 0) imm = imm | 32'hFFF80000;
    alu = (opc < 16);
    ldi = (opc == 16);
    nop = (opc == 30);
    hlt = (opc == 31);
    ill = !(alu || ldi || nop || hlt);
    exp_op  = alu ? (opc & 32'hF) : 32'd0;
    exp_rb  = alu ? rb : 32'd0;
    exp_rc  = alu ? rc : 32'd0;
    exp_sel = (alu || ldi) ? (32'd1 << ra) : 32'd0;

    for (int i = 0; i < 20 && !instr_ready; i++) @(negedge clock);
    chk("fetch_ready", 32'(instr_ready), 32'd1);
    if (!instr_ready) return;
    for (int i = 0; i < gap; i++) begin
      instr_valid = 1'b0;
      instr = $urandom;
      @(negedge clock);
      chk("stall_ready",  32'(instr_ready), 32'd1);
      chk("stall_regsel", 32'(register_select), 32'd0);
      chk("stall_pc",     32'(pc), 32'(m_pc));
    end
    instr = w;
    instr_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    instr = $urandom;
    if (chain) chk("handshake_spacing", 32'(cyc - last_hs), 32'(4 + gap));
    last_hs = cyc;

    // DECODE
    chk("dec_ready",   32'(instr_ready), 32'd0);
    chk("dec_busy",    32'(busy), 32'd1);
    chk("dec_regsel",  32'(register_select), 32'd0);
    chk("dec_illegal", 32'(illegal), 32'd0);
    @(negedge clock);

    if (hlt) begin
      chk("halt_halted",  32'(halted), 32'd1);
      chk("halt_busy",    32'(busy), 32'd0);
      chk("halt_ready",   32'(instr_ready), 32'd0);
      chk("halt_regsel",  32'(register_select), 32'd0);
      chk("halt_pc",      32'(pc), 32'(m_pc));
      chk("halt_retired", 32'(retired), 32'(m_ret));
      chain = 1'b0;
      return;
    end

    // EXEC
    chk("exec_op",      32'(op_select), exp_op);
    chk("exec_rb",      32'(rb_sel), exp_rb);
    chk("exec_rc",      32'(rc_sel), exp_rc);
    chk("exec_illegal", 32'(illegal), 32'(ill));
    chk("exec_regsel",  32'(register_select), 32'd0);
    chk("exec_busy",    32'(busy), 32'd1);
    @(negedge clock);

    // WRITE
    chk("wr_regsel",  32'(register_select), exp_sel);
    chk("wr_regset",  register_set, ldi ? imm : 32'd0);
    chk("wr_immw",    32'(imm_write), 32'(ldi));
    chk("wr_op",      32'(op_select), exp_op);
    chk("wr_rb",      32'(rb_sel), exp_rb);
    chk("wr_rc",      32'(rc_sel), exp_rc);
    chk("wr_illegal", 32'(illegal), 32'd0);
    chk("wr_pc_hold", 32'(pc), 32'(m_pc));
    @(negedge clock);

    m_pc  = m_pc + 16'd1;
    m_ret = m_ret + 16'd1;
    chk("next_ready", 32'(instr_ready), 32'd1);
    chk("pc",         32'(pc), 32'(m_pc));
    chk("retired",    32'(retired), 32'(m_ret));
    chain = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] opc;
    case ($urandom_range(0, 3))
      0, 1:    opc = 32'($urandom_range(0, 15));
      2:       opc = 32'd16;
      default: opc = ($urandom_range(0, 1) == 0) ? 32'd30 : 32'($urandom_range(17, 29));
    endcase
    return (opc << 27) | ($urandom & 32'h07FFFFFF);
  endfunction

  initial begin
    clear = 1'b0; run = 1'b0; instr = '0; instr_valid = 1'b0;
    run_w = 1'b0; instr_w = '0; valid_w = 1'b0;
    m_pc = '0; m_ret = '0; last_hs = 0; chain = 1'b0;

    // Reset state
    repeat (2) @(negedge clock);
    chk_quiet("reset");
    chk("reset_w_busy", 32'(busy_w), 32'd0);
    chk("reset_w_pc",   32'(pc_w), 32'd0);
    clear = 1'b1;
    @(negedge clock);
    chk("idle_no_run_ready", 32'(instr_ready), 32'd0);
    run = 1'b1;
    @(negedge clock);
    chk("run_to_fetch", 32'(instr_ready), 32'd1);

    // Directed instructions
    exec_instr(32'h80000005, 0);   // LDI r0,5
    exec_instr(32'h8087FFFF, 0);   // LDI r1,-1
    exec_instr(32'h19008000, 0);   // ALU op3 r2=r0,r1
    exec_instr(32'hF0000000, 3);   // NOP after 3 idle FETCH cycles

    // Randomised instruction stream
    for (int i = 0; i < 30; i++) exec_instr(rand_instr(), $urandom_range(0, 2));

    // Clear during EXEC aborts with no write
    instr = 32'h19008000;
    instr_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    instr_valid = 1'b0;
    @(negedge clock);
    chk("pre_abort_op", 32'(op_select), 32'd3);
    clear = 1'b0;
    run = 1'b0;
    #1;
    chk_quiet("abort");
    @(negedge clock);
    chk("abort_regsel", 32'(register_select), 32'd0);
    clear = 1'b1;
    m_pc = '0; m_ret = '0; chain = 1'b0;
    @(negedge clock);
    chk("abort_idle_busy", 32'(busy), 32'd0);
    run = 1'b1;
    @(negedge clock);
    chk("restart_fetch", 32'(instr_ready), 32'd1);
    exec_instr(32'h8100002A, 0);   // LDI r2,42

    // Illegal then HALT
    exec_instr(32'hA9A4C000, 0);
    exec_instr(32'hF8000000, 0);
    instr_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run = ~run;
      @(negedge clock);
      chk("halted_sticky", 32'(halted), 32'd1);
      chk("halted_busy",   32'(busy), 32'd0);
      chk("halted_ready",  32'(instr_ready), 32'd0);
      chk("halted_pc",     32'(pc), 32'(m_pc));
      chk("halted_ret",    32'(retired), 32'(m_ret));
    end
    instr_valid = 1'b0;
    clear = 1'b0;
    #1;
    chk("unhalt_halted", 32'(halted), 32'd0);
    chk("unhalt_pc",     32'(pc), 32'd0);
    @(negedge clock);
    clear = 1'b1;

    // Counter wrap with PC_W=2
    instr_w = 32'hF0000000;
    valid_w = 1'b1;
    run_w = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20 && !ready_w; i++) @(negedge clock);
      chk("wrap_ready", 32'(ready_w), 32'd1);
      @(posedge clock);
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("wrap_pc",      32'(pc_w), 32'((k + 1) % 4));
      chk("wrap_retired", 32'(retired_w), 32'((k + 1) % 4));
      chk("wrap_regsel",  32'(regsel_w), 32'd0);
    end
    valid_w = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
